alu_exec_unit: RTL and testbench

- Parametrised successor to the combinational ALU decoder.
- Merges RV32I/RV64I operation decoding with a registered execute stage and adds M-extension multiply/divide.
- Divide/remainder runs on an iterative restoring divider.
- Sits between the register-read stage and writeback; uses a valid/ready handshake on both sides so multi-cycle ops can stall the pipeline.

---
 rtl/alu_exec_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Registered RV32I/RV64I execute stage with M-extension multiply and an iterative
// restoring divider, valid/ready handshaked on both the request and result sides.
module alu_exec_unit #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned SHW      = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic            op5,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int unsigned MW = 2 * XLEN;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [0:0] {S_IDLE, S_DIV} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic [XLEN-1:0]   r_result, w_result_nxt;
  logic              r_zero, w_zero_nxt;
  logic [XLEN-1:0]   r_rem, w_rem_nxt;
  logic [XLEN-1:0]   r_quo, w_quo_nxt;
  logic [XLEN-1:0]   r_div, w_div_nxt;
  logic [SHW-1:0]    r_cnt, w_cnt_nxt;
  logic              r_neg_q, w_neg_q_nxt;
  logic              r_neg_r, w_neg_r_nxt;
  logic              r_is_rem, w_is_rem_nxt;

  logic              w_fire;
  logic [SHW-1:0]    w_shamt;
  logic              w_lt, w_ltu, w_eq, w_taken;
  logic [XLEN-1:0]   w_base_res, w_br_res, w_mul_res, w_alu_res;
  logic [MW-1:0]     w_mul_a, w_mul_b, w_mul_p;
  logic              w_is_mop, w_is_div, w_div_signed;
  logic              w_div_zero, w_div_ovf, w_div_fast;
  logic [XLEN-1:0]   w_div_fast_res;
  logic              w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic [XLEN:0]     w_div_shift, w_div_diff;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_rem_step, w_quo_step, w_div_final;
  logic              w_div_last;

  assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready) && !flush;
  assign w_fire    = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;

  assign w_shamt = src_b[SHW-1:0];
  assign w_lt    = $signed(src_a) < $signed(src_b);
  assign w_ltu   = src_a < src_b;
  assign w_eq    = src_a == src_b;

  // Base integer ops selected by funct3
  always_comb begin
    w_base_res = '0;
    case (funct3)
      3'b000:  w_base_res = (op5 && funct7_5) ? src_a - src_b : src_a + src_b;
      3'b001:  w_base_res = src_a << w_shamt;
      3'b010:  w_base_res = XLEN'(w_lt);
      3'b011:  w_base_res = XLEN'(w_ltu);
      3'b100:  w_base_res = src_a ^ src_b;
      3'b101:  w_base_res = funct7_5 ? XLEN'($signed(src_a) >>> w_shamt) : src_a >> w_shamt;
      3'b110:  w_base_res = src_a | src_b;
      default: w_base_res = src_a & src_b;
    endcase
  end

  // Branch condition, reported as a zero-extended taken bit
  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = w_eq;
      3'b001:  w_taken = !w_eq;
      3'b100:  w_taken = w_lt;
      3'b101:  w_taken = !w_lt;
      3'b110:  w_taken = w_ltu;
      3'b111:  w_taken = !w_ltu;
      default: w_taken = 1'b0;
    endcase
    w_br_res = XLEN'(w_taken);
  end

  // One double-width multiplier; operand extension picks mulh/mulhsu/mulhu
  always_comb begin
    w_mul_a = (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10) ?
              {{XLEN{src_a[XLEN-1]}}, src_a} : {{XLEN{1'b0}}, src_a};
    w_mul_b = (funct3[1:0] == 2'b01) ? {{XLEN{src_b[XLEN-1]}}, src_b} : {{XLEN{1'b0}}, src_b};
    w_mul_p = w_mul_a * w_mul_b;
    w_mul_res = (funct3[1:0] == 2'b00) ? w_mul_p[XLEN-1:0] : w_mul_p[MW-1:XLEN];
  end

  // Divide setup: special cases resolve immediately, otherwise magnitudes feed the divider
  always_comb begin
    w_is_mop       = ENABLE_M && (alu_op == 2'b10) && op5 && funct7_0;
    w_is_div       = w_is_mop && funct3[2];
    w_div_signed   = !funct3[0];
    w_div_zero     = (src_b == '0);
    w_div_ovf      = w_div_signed && (src_a == MOST_NEG) && (src_b == '1);
    w_div_fast     = w_div_zero || w_div_ovf;
    if (w_div_zero) w_div_fast_res = funct3[1] ? src_a : '1;
    else            w_div_fast_res = funct3[1] ? '0 : src_a;
    w_a_neg        = w_div_signed && src_a[XLEN-1];
    w_b_neg        = w_div_signed && src_b[XLEN-1];
    w_a_mag        = w_a_neg ? -src_a : src_a;
    w_b_mag        = w_b_neg ? -src_b : src_b;
  end

  always_comb begin
    case (alu_op)
      2'b01:   w_alu_res = w_br_res;
      2'b10:   w_alu_res = w_is_mop ? (funct3[2] ? w_div_fast_res : w_mul_res) : w_base_res;
      default: w_alu_res = src_a + src_b;
    endcase
  end

  // One restoring step per cycle; final sign fix-up applied to the last step's output
  always_comb begin
    w_div_shift = {r_rem, r_quo[XLEN-1]};
    w_div_diff  = w_div_shift - {1'b0, r_div};
    w_div_ge    = !w_div_diff[XLEN];
    w_rem_step  = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
    w_quo_step  = {r_quo[XLEN-2:0], w_div_ge};
    if (r_is_rem) w_div_final = r_neg_r ? -w_rem_step : w_rem_step;
    else          w_div_final = r_neg_q ? -w_quo_step : w_quo_step;
    w_div_last  = (r_cnt == SHW'(XLEN-1));
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_out_valid_nxt = r_out_valid;
    w_result_nxt    = r_result;
    w_zero_nxt      = r_zero;
    w_rem_nxt       = r_rem;
    w_quo_nxt       = r_quo;
    w_div_nxt       = r_div;
    w_cnt_nxt       = r_cnt;
    w_neg_q_nxt     = r_neg_q;
    w_neg_r_nxt     = r_neg_r;
    w_is_rem_nxt    = r_is_rem;
    if (flush) begin
      w_state_nxt     = S_IDLE;
      w_out_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_out_valid && out_ready) w_out_valid_nxt = 1'b0;
          if (w_fire) begin
            if (w_is_div && !w_div_fast) begin
              w_state_nxt     = S_DIV;
              w_out_valid_nxt = 1'b0;
              w_rem_nxt       = '0;
              w_quo_nxt       = w_a_mag;
              w_div_nxt       = w_b_mag;
              w_cnt_nxt       = '0;
              w_neg_q_nxt     = w_a_neg ^ w_b_neg;
              w_neg_r_nxt     = w_a_neg;
              w_is_rem_nxt    = funct3[1];
            end else begin
              w_out_valid_nxt = 1'b1;
              w_result_nxt    = w_alu_res;
              w_zero_nxt      = (w_alu_res == '0);
            end
          end
        end
        S_DIV: begin
          w_rem_nxt = w_rem_step;
          w_quo_nxt = w_quo_step;
          w_cnt_nxt = r_cnt + SHW'(1);
          if (w_div_last) begin
            w_state_nxt     = S_IDLE;
            w_out_valid_nxt = 1'b1;
            w_result_nxt    = w_div_final;
            w_zero_nxt      = (w_div_final == '0);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_is_rem    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_result    <= w_result_nxt;
      r_zero      <= w_zero_nxt;
      r_rem       <= w_rem_nxt;
      r_quo       <= w_quo_nxt;
      r_div       <= w_div_nxt;
      r_cnt       <= w_cnt_nxt;
      r_neg_q     <= w_neg_q_nxt;
      r_neg_r     <= w_neg_r_nxt;
      r_is_rem    <= w_is_rem_nxt;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit (XLEN=32, ENABLE_M=1): directed cases plus
// randomized traffic checked against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = 2'b00;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7_5 = 1'b0;
  logic        funct7_0 = 1'b0;
  logic        op5 = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic        rand_ready = 1'b0;
  logic        forced_ready = 1'b1;

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0), .op5(op5),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: instruction semantics in plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [2:0] f3,
                                            input logic f75, input logic f70, input logic o5,
                                            input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    logic [4:0]  sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    if (op == 2'b01) begin
      case (f3)
        3'd0: return {31'd0, a == b};
        3'd1: return {31'd0, a != b};
        3'd4: return {31'd0, sa < sb};
        3'd5: return {31'd0, sa >= sb};
        3'd6: return {31'd0, a < b};
        3'd7: return {31'd0, a >= b};
        default: return 32'd0;
      endcase
    end
    if (op != 2'b10) return a + b;
    if (o5 && f70) begin
      case (f3)
        3'd0: return a * b;
        3'd1: begin p = 64'(sa * sb); return p[63:32]; end
        3'd2: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
        3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
        3'd4: begin
          if (b == 0) return 32'hFFFF_FFFF;
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
          return 32'(sa / sb);
        end
        3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: begin
          if (b == 0) return a;
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
          return 32'(sa % sb);
        end
        default: return (b == 0) ? a : a % b;
      endcase
    end
    case (f3)
      3'd0: return (o5 && f75) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return {31'd0, sa < sb};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return f75 ? 32'(sa >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Monitor: pops the scoreboard on each accepted result and checks output hold
  logic        prev_hold = 1'b0, prev_flush = 1'b0, prev_zero = 1'b0;
  logic [31:0] prev_result = '0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n) begin
      if (prev_hold && !prev_flush) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_result", result, prev_result);
        check("hold_zero", {31'd0, zero}, {31'd0, prev_zero});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got %h, expected no output", result);
        end else begin
          e = exp_q.pop_front();
          check("result", result, e);
          check("zero", {31'd0, zero}, {31'd0, e == 32'd0});
        end
      end
      prev_hold   = out_valid && !out_ready;
      prev_result = result;
      prev_zero   = zero;
      prev_flush  = flush;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                      input logic f70, input logic o5, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    @(posedge clk); #1;
    alu_op = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70; op5 = o5;
    src_a = a; src_b = b; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Issue one op with the result port open and measure latency and busy cycles
  task automatic run_one(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                         input logic f70, input logic o5, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int k, low;
    send(op, f3, f75, f70, o5, a, b, exp);
    idle();
    k = 1;
    low = 0;
    @(negedge clk);
    while (!out_valid && k < 60) begin
      if (!in_ready) low++;
      k++;
      @(negedge clk);
    end
    check("latency", 32'(k), 32'(exp_lat));
    check("busy_cycles", 32'(low), 32'(exp_lat - 1));
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #3;
      if (exp_q.size() == 0) break;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      4: return -32'($urandom_range(1, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cnt;
    logic [1:0]  r_op;
    logic [2:0]  r_f3;
    logic        r_f75, r_f70, r_o5;
    logic [31:0] r_a, r_b;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;

    run_one(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    run_one(2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1);
    run_one(2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
    run_one(2'b10, 3'b101, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h24, 32'h0800_0000, 1);
    run_one(2'b01, 3'b100, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_one(2'b01, 3'b110, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_one(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, -32'd7, 32'd2, 32'hFFFF_FFFD, 33);
    run_one(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, -32'd7, 32'd2, 32'hFFFF_FFFF, 33);
    run_one(2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1);
    run_one(2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd1234, 32'd0, 32'd1234, 1);
    run_one(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_one(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_one(2'b10, 3'b001, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1);

    // Result held while the consumer stalls
    forced_ready = 1'b0;
    send(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h1234, 32'd1, 32'h1235);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_result", result, 32'h1235);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    forced_ready = 1'b1;
    drain();

    // Flush mid-divide
    send(2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd100, 32'd3, 32'd33);
    idle();
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b1;
    alu_op = 2'b00; src_a = 32'd1; src_b = 32'd2; in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_flush_valid", {31'd0, out_valid}, 32'd0);
    check("post_flush_in_ready", {31'd0, in_ready}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("flush_no_result", 32'(cnt), 32'd0);

    // Asynchronous reset mid-divide
    run_one(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1);
    send(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'd1000, 32'd7, 32'd142);
    idle();
    repeat (10) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_result", result, 32'd0);
    check("arst_zero", {31'd0, zero}, 32'd1);
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);

    // Randomized back-to-back traffic with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r_op  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) r_op = 2'b10;
      r_f3  = 3'($urandom_range(0, 7));
      r_f75 = 1'($urandom_range(0, 1));
      r_f70 = 1'($urandom_range(0, 1));
      r_o5  = 1'($urandom_range(0, 1));
      r_a   = pick_operand();
      r_b   = pick_operand();
      send(r_op, r_f3, r_f75, r_f70, r_o5, r_a, r_b,
           ref_model(r_op, r_f3, r_f75, r_f70, r_o5, r_a, r_b));
    end
    idle();
    rand_ready = 1'b0;
    forced_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
